// File: rtl/serial_deserializer.sv
// rtl/serial_deserializer.sv - LSB-first serial-to-parallel word receiver
// Optional even-parity bit per frame: define DESER_PARITY_EN.
module serial_deserializer #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         SI,
   input  logic         shift_en,
   input  logic         sync,
   output logic [N-1:0] Q,
   output logic         valid,
   output logic         busy,
   output logic         parity_err
);

   localparam int CW = $clog2(N + 1);

`ifdef DESER_PARITY_EN
   typedef enum logic [1:0] {IDLE, RECV, PAR} state_t;
`else
   typedef enum logic [1:0] {IDLE, RECV} state_t;
`endif

   state_t          r_state;
   logic [N-1:0]    r_sh;
   logic [CW-1:0]   r_cnt;
   logic [N-1:0]    r_q;
   logic            r_valid;

   state_t          w_base_state;
   logic [N-1:0]    w_base_sh;
   logic [CW-1:0]   w_base_cnt;
   logic [N-1:0]    w_shifted;
   logic [CW-1:0]   w_cnt_inc;

   state_t          w_nxt_state;
   logic [N-1:0]    w_nxt_sh;
   logic [CW-1:0]   w_nxt_cnt;
   logic [N-1:0]    w_nxt_q;
   logic            w_nxt_valid;

   // sync first wipes the partial frame; a bit sampled alongside it then starts a new word
   assign w_base_state = sync ? IDLE : r_state;
   assign w_base_sh    = sync ? '0 : r_sh;
   assign w_base_cnt   = sync ? '0 : r_cnt;
   assign w_cnt_inc    = w_base_cnt + CW'(1);

   generate
      if (N == 1) begin : g_shift_n1
         assign w_shifted = SI;
      end else begin : g_shift_nx
         assign w_shifted = {SI, w_base_sh[N-1:1]};
      end
   endgenerate

`ifdef DESER_PARITY_EN
   logic r_perr;
   logic w_nxt_perr;
`endif

   always_comb begin
      w_nxt_state = w_base_state;
      w_nxt_sh    = w_base_sh;
      w_nxt_cnt   = w_base_cnt;
      w_nxt_q     = r_q;
      w_nxt_valid = 1'b0;
`ifdef DESER_PARITY_EN
      w_nxt_perr  = r_perr;
`endif
      if (shift_en) begin
         case (w_base_state)
`ifdef DESER_PARITY_EN
            PAR: begin
               w_nxt_q     = w_base_sh;
               w_nxt_perr  = (^w_base_sh) ^ SI;
               w_nxt_valid = 1'b1;
               w_nxt_cnt   = '0;
               w_nxt_state = IDLE;
            end
`endif
            IDLE, RECV: begin
               w_nxt_sh = w_shifted;
               if (w_cnt_inc == CW'(N)) begin
                  w_nxt_cnt = '0;
`ifdef DESER_PARITY_EN
                  w_nxt_state = PAR;
`else
                  w_nxt_q     = w_shifted;
                  w_nxt_valid = 1'b1;
                  w_nxt_state = IDLE;
`endif
               end else begin
                  w_nxt_cnt   = w_cnt_inc;
                  w_nxt_state = RECV;
               end
            end
            default: begin
               w_nxt_cnt   = '0;
               w_nxt_state = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_sh    <= '0;
         r_cnt   <= '0;
         r_q     <= '0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         r_sh    <= w_nxt_sh;
         r_cnt   <= w_nxt_cnt;
         r_q     <= w_nxt_q;
         r_valid <= w_nxt_valid;
      end
   end

`ifdef DESER_PARITY_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_perr <= 1'b0;
      else          r_perr <= w_nxt_perr;
   end
   assign parity_err = r_perr;
`else
   assign parity_err = 1'b0;
`endif

   assign Q     = r_q;
   assign valid = r_valid;
   assign busy  = (r_state != IDLE);

endmodule

// File: tb/tb_serial_deserializer.sv
// tb/tb_serial_deserializer.sv - vector table plus scoreboard bench for serial_deserializer
module tb_serial_deserializer;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         SI;
   logic         shift_en;
   logic         sync;
   logic [N-1:0] Q;
   logic         valid;
   logic         busy;
   logic         parity_err;

   serial_deserializer #(.N(N)) dut (
      .clk(clk), .reset_n(reset_n), .SI(SI), .shift_en(shift_en), .sync(sync),
      .Q(Q), .valid(valid), .busy(busy), .parity_err(parity_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         sy;
      logic         en;
      logic         si;
      logic         ev;
      logic         eb;
      logic [N-1:0] eq;
      logic         ep;
   } vec_t;

   typedef struct {
      logic [N-1:0] q;
      logic         p;
   } exp_t;

   vec_t tbl[$];
   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;
   int   n_valid = 0;
   int   n_exp = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic void add(input logic sy, input logic en, input logic si, input logic ev,
                               input logic eb, input logic [N-1:0] eq, input logic ep);
      vec_t v;
      v.sy = sy; v.en = en; v.si = si; v.ev = ev; v.eb = eb; v.eq = eq; v.ep = ep;
      tbl.push_back(v);
   endfunction

   always @(negedge clk) begin
      if (reset_n === 1'b1 && valid === 1'b1) begin
         exp_t e;
         n_valid++;
         if (sbq.size() == 0) begin
            chk("valid_without_expect", {31'd0, valid}, 32'd0);
         end else begin
            e = sbq.pop_front();
            chk("q_word", {28'd0, Q}, {28'd0, e.q});
            chk("parity_err", {31'd0, parity_err}, {31'd0, e.p});
         end
      end
   end

   initial begin
      reset_n = 1'b0; SI = 1'b0; shift_en = 1'b0; sync = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_q", {28'd0, Q}, 32'd0);
      chk("reset_valid", {31'd0, valid}, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_perr", {31'd0, parity_err}, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // two bits then an asynchronous reset away from any clock edge
      shift_en = 1'b1; SI = 1'b1;
      repeat (2) @(negedge clk);
      shift_en = 1'b0;
      chk("busy_before_reset", {31'd0, busy}, 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("async_reset_busy", {31'd0, busy}, 32'd0);
      chk("async_reset_q", {28'd0, Q}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

`ifdef DESER_PARITY_EN
      for (int k = 0; k < 4; k++) add(0, 1, 1, 0, 1, '0, 0);
      add(0, 1, 0, 1, 0, 4'hF, 0);
      add(0, 1, 1, 0, 1, '0, 0); add(0, 1, 0, 0, 1, '0, 0);
      add(0, 1, 1, 0, 1, '0, 0); add(0, 1, 1, 0, 1, '0, 0);
      add(0, 1, 1, 1, 0, 4'hD, 0);
      add(0, 1, 1, 0, 1, '0, 0); add(0, 1, 0, 0, 1, '0, 0);
      add(0, 1, 1, 0, 1, '0, 0); add(0, 1, 1, 0, 1, '0, 0);
      add(0, 1, 0, 1, 0, 4'hD, 1);
      add(0, 0, 0, 0, 0, '0, 0);
`else
      // post-reset word 1,1,1,1
      add(0, 1, 1, 0, 1, '0, 0); add(0, 1, 1, 0, 1, '0, 0);
      add(0, 1, 1, 0, 1, '0, 0); add(0, 1, 1, 1, 0, 4'hF, 0);
      // 1,0,1,1 back-to-back
      add(0, 1, 1, 0, 1, '0, 0); add(0, 1, 0, 0, 1, '0, 0);
      add(0, 1, 1, 0, 1, '0, 0); add(0, 1, 1, 1, 0, 4'hD, 0);
      add(0, 0, 0, 0, 0, '0, 0);
      // 0,1,1,0 with 3-cycle gaps
      add(0, 1, 0, 0, 1, '0, 0);
      for (int k = 0; k < 3; k++) add(0, 0, 1, 0, 1, '0, 0);
      add(0, 1, 1, 0, 1, '0, 0);
      for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 1, '0, 0);
      add(0, 1, 1, 0, 1, '0, 0);
      for (int k = 0; k < 3; k++) add(0, 0, 1, 0, 1, '0, 0);
      add(0, 1, 0, 1, 0, 4'h6, 0);
      add(0, 0, 0, 0, 0, '0, 0);
      // 1,1 aborted by sync+shift_en carrying bit 0 of 0,1,0,1
      add(0, 1, 1, 0, 1, '0, 0); add(0, 1, 1, 0, 1, '0, 0);
      add(1, 1, 0, 0, 1, '0, 0);
      add(0, 1, 1, 0, 1, '0, 0); add(0, 1, 0, 0, 1, '0, 0);
      add(0, 1, 1, 1, 0, 4'hA, 0);
      // sync on the 4th bit suppresses completion; sync alone goes idle
      add(0, 1, 1, 0, 1, '0, 0); add(0, 1, 1, 0, 1, '0, 0);
      add(0, 1, 1, 0, 1, '0, 0); add(1, 1, 1, 0, 1, '0, 0);
      add(1, 0, 0, 0, 0, '0, 0);
      // 8 bits streamed: 1,0,0,0 then 0,0,0,1
      add(0, 1, 1, 0, 1, '0, 0); add(0, 1, 0, 0, 1, '0, 0);
      add(0, 1, 0, 0, 1, '0, 0); add(0, 1, 0, 1, 0, 4'h1, 0);
      add(0, 1, 0, 0, 1, '0, 0); add(0, 1, 0, 0, 1, '0, 0);
      add(0, 1, 0, 0, 1, '0, 0); add(0, 1, 1, 1, 0, 4'h8, 0);
      add(0, 0, 0, 0, 0, '0, 0);
`endif

      for (int i = 0; i < tbl.size(); i++) begin
         sync = tbl[i].sy; shift_en = tbl[i].en; SI = tbl[i].si;
         if (tbl[i].ev) begin
            exp_t e;
            e.q = tbl[i].eq; e.p = tbl[i].ep;
            sbq.push_back(e);
            n_exp++;
         end
         @(negedge clk);
         chk($sformatf("valid@%0d", i), {31'd0, valid}, {31'd0, tbl[i].ev});
         chk($sformatf("busy@%0d", i), {31'd0, busy}, {31'd0, tbl[i].eb});
      end
      sync = 1'b0; shift_en = 1'b0; SI = 1'b0;
      repeat (3) @(negedge clk);
      chk("valid_count", n_valid, n_exp);
      chk("scoreboard_empty", sbq.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
